// File: rtl/mem_pkg.sv
// Shared types and widths for the beta-core data-memory responder.
// Used by mem_responder and mem_array.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read by index.
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Slave end of the beta core data port: posted writes, wait-stated reads.
// Define MEM_RESP_ALIGN_CHECK_EN to flag and drop misaligned accesses via MemErr.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memWriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemReadDone,
  output logic [31:0]       memReadData,
  output logic              MemReadReady,
  output logic              MemBusy,
  output logic              MemErr
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [AW-1:0]     addr_idx;
  logic              access_ok;
  logic              wr_en;
  logic              rd_req;
  logic              wr_hit;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] sample_data;
  logic              unused_addr_bits;

  assign addr_idx         = memAddr[AW+1:2];
  assign unused_addr_bits = ^{memAddr[31:AW+2], memAddr[1:0]};

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign access_ok = (memAddr[1:0] == 2'b00);
`else
  assign access_ok = 1'b1;
`endif

  assign wr_en  = MemWrite && access_ok;
  assign rd_req = MemRead && !MemWrite && access_ok;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (addr_idx),
    .wdata (memWriteData),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );

  // A write landing on the final WAIT edge must still reach the pending read.
  assign wr_hit      = wr_en && (addr_idx == idx_q);
  assign sample_data = wr_hit ? memWriteData : arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    err_d   = (MemRead || MemWrite) && !access_ok;
`endif
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          idx_d   = addr_idx;
        end
      end
      WAIT: begin
        if (!MemRead) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = READY;
          rdata_d = sample_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY: begin
        if (!MemRead || MemReadDone) begin
          state_d = IDLE;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign memReadData  = rdata_q;
  assign MemReadReady = (state_q == READY);
  assign MemBusy      = (state_q != IDLE);
`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign MemErr = err_q;
`else
  assign MemErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a word-array model.
// Honors MEM_RESP_ALIGN_CHECK_EN when deciding whether misaligned writes land.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        MemReadDone;
  logic [31:0] memReadData;
  logic        MemReadReady;
  logic        MemBusy;
  logic        MemErr;

  bit [31:0]   model_mem [DEPTH];
  int unsigned written_idx [$];
  int          checks = 0;
  int          errors = 0;

  mem_responder #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadDone  (MemReadDone),
    .memReadData  (memReadData),
    .MemReadReady (MemReadReady),
    .MemBusy      (MemBusy),
    .MemErr       (MemErr)
  );

  always #5 clk = ~clk;

  function automatic bit access_ok(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    return (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: the model memory absorbs any write the DUT should accept at this edge.
  task automatic tick();
    @(posedge clk);
    if (MemWrite === 1'b1 && access_ok(memAddr)) begin
      model_mem[word_of(memAddr)] = memWriteData;
      written_idx.push_back(word_of(memAddr));
    end
    #1;
  endtask

  task automatic apply_write(input logic [31:0] addr, input logic [31:0] data);
    memAddr      = addr;
    memWriteData = data;
    MemWrite     = 1'b1;
    MemRead      = 1'b0;
    tick();
    MemWrite     = 1'b0;
  endtask

  task automatic apply_read(input logic [31:0] addr, input int hold, input bit inj,
                            input logic [31:0] inj_data, input bit early_done,
                            input bit ready_wr);
    logic [31:0] exp;
    memAddr     = addr;
    MemRead     = 1'b1;
    MemWrite    = 1'b0;
    MemReadDone = 1'b0;
    tick();
    check_output("busy_after_accept", 32'(MemBusy), 32'd1);
    if (inj) begin
      MemWrite     = 1'b1;
      memWriteData = inj_data;
    end
    MemReadDone = early_done;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      MemWrite = 1'b0;
      if (i < LAT) begin
        check_output("ready_in_wait", 32'(MemReadReady), 32'd0);
        check_output("data_zero_in_wait", memReadData, 32'd0);
      end
    end
    MemReadDone = 1'b0;
    exp = model_mem[word_of(addr)];
    check_output("ready_at_latency", 32'(MemReadReady), 32'd1);
    check_output("read_data", memReadData, exp);
    for (int h = 0; h < hold; h++) begin
      if (ready_wr && h == 0) begin
        MemWrite     = 1'b1;
        memWriteData = ~exp;
      end
      tick();
      MemWrite = 1'b0;
      check_output("ready_held", 32'(MemReadReady), 32'd1);
      check_output("data_held", memReadData, exp);
    end
    MemReadDone = 1'b1;
    tick();
    MemReadDone = 1'b0;
    MemRead     = 1'b0;
    check_output("ready_after_done", 32'(MemReadReady), 32'd0);
    check_output("busy_after_done", 32'(MemBusy), 32'd0);
    check_output("data_after_done", memReadData, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] upper;
    int unsigned pick;

    rst_n        = 1'b1;
    memAddr      = '0;
    memWriteData = '0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemReadDone  = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    check_output("reset_ready", 32'(MemReadReady), 32'd0);
    check_output("reset_busy", 32'(MemBusy), 32'd0);
    check_output("reset_err", 32'(MemErr), 32'd0);
    check_output("reset_data", memReadData, 32'd0);
    rst_n = 1'b1;
    tick();

    apply_write(32'h10, 32'hDEADBEEF);
    apply_read(32'h10, 2, 1'b0, '0, 1'b0, 1'b0);

    apply_write(32'h20, 32'hA5A5_0F0F);
    apply_read(32'h20, 5, 1'b0, '0, 1'b1, 1'b1);
    apply_read(32'h20, 0, 1'b0, '0, 1'b0, 1'b0);

    apply_write(32'h24, 32'h0BAD_F00D);
    memAddr = 32'h24;
    MemRead = 1'b1;
    tick();
    tick();
    MemRead = 1'b0;
    tick();
    check_output("abort_busy", 32'(MemBusy), 32'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check_output("abort_no_ready", 32'(MemReadReady), 32'd0);
    end
    apply_read(32'h24, 1, 1'b0, '0, 1'b0, 1'b0);

    apply_write(32'h30, 32'h1111_2222);
    apply_read(32'h30, 1, 1'b1, 32'h12345678, 1'b0, 1'b0);

    apply_write(32'h1000, 32'hCAFE_0001);
    apply_read(32'h0, 0, 1'b0, '0, 1'b0, 1'b0);

    apply_write(32'h50, 32'h5555_AAAA);
    memAddr = 32'h50;
    MemRead = 1'b1;
    for (int i = 0; i <= LAT; i++) tick();
    check_output("ready_before_reset", 32'(MemReadReady), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_ready", 32'(MemReadReady), 32'd0);
    check_output("async_reset_busy", 32'(MemBusy), 32'd0);
    check_output("async_reset_data", memReadData, 32'd0);
    check_output("async_reset_err", 32'(MemErr), 32'd0);
    MemRead = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      check_output("no_ready_after_reset", 32'(MemReadReady), 32'd0);
    end

    apply_write(32'h40, 32'h4040_4040);
    memAddr      = 32'h42;
    memWriteData = 32'hBADD_BADD;
    MemWrite     = 1'b1;
    tick();
    MemWrite = 1'b0;
    check_output("misaligned_err", 32'(MemErr), 32'(!access_ok(32'h42)));
    tick();
    check_output("err_one_cycle", 32'(MemErr), 32'd0);
    apply_read(32'h40, 0, 1'b0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      upper = $urandom;
      addr  = (upper & ~32'(DEPTH * 4 - 1)) | (32'($urandom_range(0, DEPTH - 1)) << 2);
      apply_write(addr, $urandom);
      pick  = written_idx[$urandom_range(0, written_idx.size() - 1)];
      upper = $urandom;
      addr  = (upper & ~32'(DEPTH * 4 - 1)) | (32'(pick) << 2);
      apply_read(addr, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the beta core: the slave end of the core's memAddr/MemRead/MemWrite/MemReadReady/memReadData/MemReadDone protocol. Holds a word-addressed storage array, accepts single-cycle posted writes, and answers reads after a programmable wait-state latency, holding data valid until the core's cache acknowledges with MemReadDone. It sits between the beta core's data port and the testbench/top-level memory map.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- READ_LATENCY, 3, cycles from read acceptance to MemReadReady; legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- memAddr  in  32  byte address from core; word index = memAddr[log2(DEPTH)+1:2].
- memWriteData  in  32  write data.
- MemRead  in  1  read request; held high by core until done.
- MemWrite  in  1  write strobe; one write per high cycle.
- MemReadDone  in  1  core/cache acknowledge of returned data.
- memReadData  out  32  read data; valid only while MemReadReady.
- MemReadReady  out  1  read data valid.
- MemBusy  out  1  high in WAIT and READY.
- MemErr  out  1  misaligned-access flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE: MemRead=1 and MemWrite=0 -> latch word index, load counter with READ_LATENCY-1, go WAIT. MemRead=1 with MemWrite=1 -> write only, stay IDLE; read starts next cycle if MemRead still high.
- WAIT: counter decrements each cycle; at counter=0 go READY and register array[latched index] into memReadData.
- READY: MemReadReady=1, memReadData held stable. MemReadDone=1 -> IDLE next cycle. Stays in READY indefinitely while MemReadDone=0 and MemRead=1.
- Abort: MemRead=0 in WAIT or READY -> IDLE next cycle, no ready pulse, data discarded.
- Writes: accepted in every state on any cycle with MemWrite=1; array[index] <= memWriteData at that edge. A write to the latched read address during WAIT is visible to that read (array sampled on WAIT->READY transition). A write during READY does not change held memReadData.
- Address wrap: bits above log2(DEPTH)+1 ignored; index is modulo DEPTH.
- memReadData = 0 whenever MemReadReady=0.

## Timing
- Reset: state IDLE, counter 0, memReadData 0, MemReadReady 0, MemBusy 0, MemErr 0. Array contents not cleared. Reset asserted mid-read aborts immediately; no ready after release.
- Read latency: request accepted at edge N -> MemReadReady high from edge N+READ_LATENCY.
- Earliest back-to-back read: MemReadDone at edge M -> IDLE after M; new read accepted at M+1.
- Write latency: 0 extra cycles; read issued the cycle after a write returns the written word.
- MemReadDone outside READY is ignored.

## Configuration
- MEM_RESP_ALIGN_CHECK_EN defined: any MemRead or MemWrite cycle with memAddr[1:0]!=0 sets MemErr for exactly that cycle (registered, visible one cycle later); misaligned write is dropped, misaligned read is not accepted (FSM stays IDLE).
- Undefined: MemErr tied 0; memAddr[1:0] ignored, all accesses proceed.

## Structure
- Package mem_pkg: state enum (IDLE, WAIT, READY), word width constant 32, latency-counter width 4.
- Sub-module mem_array: DEPTH×32 storage, synchronous write, combinational read by index; responder FSM and counter live in mem_responder.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 with READ_LATENCY=3 -> MemReadReady high exactly 3 cycles after acceptance, memReadData=0xDEADBEEF, held until MemReadDone.
- Read 0x20 holding MemReadDone=0 for 5 cycles -> ready and data stable all 5 cycles; Done -> IDLE, MemBusy=0 next cycle.
- Drop MemRead in WAIT cycle 2 -> no ready pulse; subsequent read to 0x24 returns correct data.
- Write 0x12345678 to 0x30 while read of 0x30 is in WAIT -> read returns 0x12345678.
- Address 0x1000 with DEPTH=1024 -> aliases word 0; reset pulled low during READY -> all outputs 0 immediately.
- With MEM_RESP_ALIGN_CHECK_EN, write to 0x42 -> MemErr one-cycle pulse, word 0x40 unchanged; without macro, MemErr stays 0.
